// File: rtl/vector_strip_sequencer_pkg.sv
// Shared constants for the vector strip sequencer and the 8-lane vector ALU block.
// Holds the geometry constants, the sequencer state encodings, the ALU op codes
// and the vector-length clamp helper.
package vector_strip_sequencer_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned MAXVL   = 32;
  localparam int unsigned VREG_W  = 3;
  localparam int unsigned CHUNK_W = 2;

  // Sequencer state encodings
  typedef logic [1:0] vseq_state_t;
  localparam vseq_state_t ST_IDLE  = 2'd0;
  localparam vseq_state_t ST_ISSUE = 2'd1;
  localparam vseq_state_t ST_DRAIN = 2'd2;

  // ALU operation codes, shared with the ALU block
  localparam logic [2:0] VOP_ADD = 3'd0;
  localparam logic [2:0] VOP_SUB = 3'd1;
  localparam logic [2:0] VOP_AND = 3'd2;
  localparam logic [2:0] VOP_OR  = 3'd3;
  localparam logic [2:0] VOP_XOR = 3'd4;
  localparam logic [2:0] VOP_SLL = 3'd5;
  localparam logic [2:0] VOP_SRL = 3'd6;
  localparam logic [2:0] VOP_MUL = 3'd7;

  // Requested lengths above MAXVL are silently clamped
  function automatic logic [5:0] clamp_vl(input logic [5:0] vl);
    return (vl > 6'(MAXVL)) ? 6'(MAXVL) : vl;
  endfunction

endpackage

// File: rtl/vector_strip_sequencer_lane_mask.sv
// vseq_lane_mask: combinational per-lane enable for one chunk.
// Lane i is active when element (chunk*LANES + i) lies below the effective VL.
// With VSEQ_PRED_MASK_EN defined the result is further ANDed with the element
// predicate slice belonging to the chunk.
module vseq_lane_mask
  import vector_strip_sequencer_pkg::*;
#(
  parameter int unsigned P_LANES   = 8,
  parameter int unsigned P_MAXVL   = 32,
  parameter int unsigned P_CHUNK_W = 2
) (
  input  logic [P_CHUNK_W-1:0] chunk,
  input  logic [5:0]           evl,
`ifdef VSEQ_PRED_MASK_EN
  input  logic [P_MAXVL-1:0]   pmask,
`endif
  output logic [P_LANES-1:0]   mask
);

  localparam int unsigned LANE_W = $clog2(P_LANES);

  logic [5:0]         base;
  logic [5:0]         idx;
  logic [P_LANES-1:0] vl_mask;
`ifdef VSEQ_PRED_MASK_EN
  logic [P_MAXVL-1:0] pshift;
`endif

  // Element index formed by shift/or so the compare stays a 6-bit comparator
  always_comb begin
    base    = 6'(chunk) << LANE_W;
    idx     = '0;
    vl_mask = '0;
    for (int unsigned i = 0; i < P_LANES; i++) begin
      idx        = base | 6'(i);
      vl_mask[i] = (idx < evl);
    end
`ifdef VSEQ_PRED_MASK_EN
    pshift = pmask >> base;
    mask   = vl_mask & pshift[P_LANES-1:0];
`else
    mask   = vl_mask;
`endif
  end

endmodule

// File: rtl/vector_strip_sequencer.sv
// vector_strip_sequencer: strip-mines one vector instruction (VL 0..63, clamped
// to MAXVL) into LANES-element chunks, issuing one register-file read per cycle
// and the matching masked writeback one cycle later, then pulses done.
// Optional feature macro: VSEQ_PRED_MASK_EN (adds instr_pmask element predicate).
module vector_strip_sequencer #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned MAXVL   = 32,
  parameter int unsigned VREG_W  = 3,
  parameter int unsigned CHUNK_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         instr_op,
  input  logic [VREG_W-1:0]  instr_vd,
  input  logic [VREG_W-1:0]  instr_vs1,
  input  logic [VREG_W-1:0]  instr_vs2,
  input  logic [5:0]         instr_vl,
`ifdef VSEQ_PRED_MASK_EN
  input  logic [MAXVL-1:0]   instr_pmask,
`endif
  output logic               rf_rd_en,
  output logic [VREG_W-1:0]  rf_rd_vs1,
  output logic [VREG_W-1:0]  rf_rd_vs2,
  output logic [CHUNK_W-1:0] rf_rd_chunk,
  output logic [LANES-1:0]   valu_ena,
  output logic [2:0]         valu_sel,
  output logic               wb_en,
  output logic [VREG_W-1:0]  wb_vd,
  output logic [CHUNK_W-1:0] wb_chunk,
  output logic [LANES-1:0]   wb_mask,
  output logic               busy,
  output logic               done
);

  import vector_strip_sequencer_pkg::*;

  localparam int unsigned LANE_W = $clog2(LANES);

  vseq_state_t        state;
  logic [2:0]         op_q;
  logic [VREG_W-1:0]  vd_q;
  logic [VREG_W-1:0]  vs1_q;
  logic [VREG_W-1:0]  vs2_q;
  logic [5:0]         evl_q;
  logic [CHUNK_W-1:0] last_q;
  logic [CHUNK_W-1:0] chunk_q;
`ifdef VSEQ_PRED_MASK_EN
  logic [MAXVL-1:0]   pmask_q;
`endif

  logic [5:0]         evl_in;
  logic [5:0]         evl_m1;
  logic [CHUNK_W-1:0] last_in;
  logic [LANES-1:0]   lane_mask;

  // Effective VL and index of the final chunk for the offered instruction
  always_comb begin
    evl_in  = clamp_vl(instr_vl);
    evl_m1  = evl_in - 6'd1;
    last_in = CHUNK_W'(evl_m1 >> LANE_W);
  end

  vseq_lane_mask #(
    .P_LANES   (LANES),
    .P_MAXVL   (MAXVL),
    .P_CHUNK_W (CHUNK_W)
  ) u_lane_mask (
    .chunk (chunk_q),
    .evl   (evl_q),
`ifdef VSEQ_PRED_MASK_EN
    .pmask (pmask_q),
`endif
    .mask  (lane_mask)
  );

  // Sequencer FSM: accept and latch, walk chunks, one drain cycle to retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      evl_q   <= '0;
      last_q  <= '0;
      chunk_q <= '0;
`ifdef VSEQ_PRED_MASK_EN
      pmask_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            vd_q    <= instr_vd;
            vs1_q   <= instr_vs1;
            vs2_q   <= instr_vs2;
            evl_q   <= evl_in;
            last_q  <= last_in;
            chunk_q <= '0;
`ifdef VSEQ_PRED_MASK_EN
            pmask_q <= instr_pmask;
`endif
            state   <= (evl_in == 6'd0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          chunk_q <= chunk_q + 1'b1;
          if (chunk_q == last_q) state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Read strobe and indices decoded from state; quiet outside ISSUE
  always_comb begin
    instr_ready = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    done        = (state == ST_DRAIN);
    rf_rd_en    = (state == ST_ISSUE);
    rf_rd_vs1   = rf_rd_en ? vs1_q   : '0;
    rf_rd_vs2   = rf_rd_en ? vs2_q   : '0;
    rf_rd_chunk = rf_rd_en ? chunk_q : '0;
    wb_mask     = valu_ena;
  end

  // ALU controls and writeback follow the read by one cycle to meet the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en    <= 1'b0;
      valu_ena <= '0;
      valu_sel <= '0;
      wb_vd    <= '0;
      wb_chunk <= '0;
    end else if (rf_rd_en) begin
      wb_en    <= 1'b1;
      valu_ena <= lane_mask;
      valu_sel <= op_q;
      wb_vd    <= vd_q;
      wb_chunk <= chunk_q;
    end else begin
      wb_en    <= 1'b0;
      valu_ena <= '0;
      valu_sel <= '0;
      wb_vd    <= '0;
      wb_chunk <= '0;
    end
  end

endmodule

// File: tb/tb_vector_strip_sequencer.sv
// Scoreboard bench for vector_strip_sequencer. The driver pushes the expected
// read, writeback and done events (with their cycle stamps) for each directed
// instruction; an independent negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vector_strip_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [2:0] instr_vd, instr_vs1, instr_vs2;
  logic [5:0] instr_vl;
  logic [31:0] instr_pmask;
  logic       rf_rd_en;
  logic [2:0] rf_rd_vs1, rf_rd_vs2;
  logic [1:0] rf_rd_chunk;
  logic [7:0] valu_ena;
  logic [2:0] valu_sel;
  logic       wb_en;
  logic [2:0] wb_vd;
  logic [1:0] wb_chunk;
  logic [7:0] wb_mask;
  logic       busy, done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [2:0] vs1; logic [2:0] vs2; logic [1:0] chunk; } rd_t;
  typedef struct { int cyc; logic [2:0] vd; logic [1:0] chunk; logic [7:0] mask; logic [2:0] sel; } wb_t;

  rd_t rd_q[$];
  wb_t wb_q[$];
  int  done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_strip_sequencer #(
    .LANES   (8),
    .MAXVL   (32),
    .VREG_W  (3),
    .CHUNK_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_vd    (instr_vd),
    .instr_vs1   (instr_vs1),
    .instr_vs2   (instr_vs2),
    .instr_vl    (instr_vl),
`ifdef VSEQ_PRED_MASK_EN
    .instr_pmask (instr_pmask),
`endif
    .rf_rd_en    (rf_rd_en),
    .rf_rd_vs1   (rf_rd_vs1),
    .rf_rd_vs2   (rf_rd_vs2),
    .rf_rd_chunk (rf_rd_chunk),
    .valu_ena    (valu_ena),
    .valu_sel    (valu_sel),
    .wb_en       (wb_en),
    .wb_vd       (wb_vd),
    .wb_chunk    (wb_chunk),
    .wb_mask     (wb_mask),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the head of its queue
  rd_t rd_e;
  wb_t wb_e;
  int  dn_e;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rf_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else begin
          rd_e = rd_q.pop_front();
          check("rd", {32'(cyc), 8'(rf_rd_vs1), 8'(rf_rd_vs2), 8'(rf_rd_chunk), 8'd0},
                      {32'(rd_e.cyc), 8'(rd_e.vs1), 8'(rd_e.vs2), 8'(rd_e.chunk), 8'd0});
        end
      end
      if (wb_en) begin
        if (wb_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
        else begin
          wb_e = wb_q.pop_front();
          check("wb", {32'(cyc), 4'(wb_vd), 4'(wb_chunk), wb_mask, valu_ena, 4'(valu_sel)},
                      {32'(wb_e.cyc), 4'(wb_e.vd), 4'(wb_e.chunk), wb_e.mask, wb_e.mask, 4'(wb_e.sel)});
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else begin
          dn_e = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(dn_e));
        end
      end
    end
  end

  // Offer one instruction; n and masks are the hand-computed chunk count and
  // per-chunk masks packed 8 bits per chunk
  task automatic issue(input logic [2:0] op, input logic [2:0] vd, input logic [2:0] vs1,
                       input logic [2:0] vs2, input logic [5:0] vl, input logic [31:0] pm,
                       input int n, input logic [31:0] masks);
    int t = 0;
    int a;
    @(negedge clk);
    while (!instr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_vd    = vd;
    instr_vs1   = vs1;
    instr_vs2   = vs2;
    instr_vl    = vl;
    instr_pmask = pm;
    a = cyc;
    for (int k = 0; k < n; k++) begin
      rd_q.push_back('{a + 1 + k, vs1, vs2, 2'(k)});
      wb_q.push_back('{a + 2 + k, vd, 2'(k), masks[8*k +: 8], op});
    end
    done_q.push_back(a + n + 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = '0; instr_vd = '0; instr_vs1 = '0; instr_vs2 = '0;
    instr_vl = '0; instr_pmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          64'({rf_rd_en, rf_rd_vs1, rf_rd_vs2, rf_rd_chunk, valu_ena, valu_sel, wb_en,
               wb_vd, wb_chunk, wb_mask, busy, done, instr_ready}), 64'd1);
    rst = 1'b0;

    issue(3'd0, 3'd3, 3'd1, 3'd2, 6'd32, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF);
    issue(3'd5, 3'd4, 3'd6, 3'd7, 6'd13, 32'hFFFF_FFFF, 2, 32'h0000_1FFF);
    issue(3'd2, 3'd1, 3'd0, 3'd0, 6'd0,  32'hFFFF_FFFF, 0, 32'h0);
    issue(3'd7, 3'd5, 3'd3, 3'd4, 6'd50, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF);
    issue(3'd1, 3'd0, 3'd0, 3'd0, 6'd1,  32'hFFFF_FFFF, 1, 32'h0000_0001);
    issue(3'd3, 3'd2, 3'd2, 3'd5, 6'd9,  32'hFFFF_FFFF, 2, 32'h0000_01FF);
    issue(3'd4, 3'd6, 3'd7, 3'd6, 6'd31, 32'hFFFF_FFFF, 4, 32'h7FFF_FFFF);
    issue(3'd6, 3'd7, 3'd5, 3'd1, 6'd33, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF);
    issue(3'd2, 3'd3, 3'd3, 3'd3, 6'd8,  32'hFFFF_FFFF, 1, 32'h0000_00FF);

    // Reset on the second ISSUE cycle of a full-length instruction
    issue(3'd0, 3'd3, 3'd1, 3'd2, 6'd32, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_outputs",
          64'({rf_rd_en, rf_rd_vs1, rf_rd_vs2, rf_rd_chunk, valu_ena, valu_sel, wb_en,
               wb_vd, wb_chunk, wb_mask, busy, done, instr_ready}), 64'd1);
    rd_q.delete();
    wb_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    issue(3'd1, 3'd2, 3'd4, 3'd5, 6'd20, 32'hFFFF_FFFF, 3, 32'h000F_FFFF);

`ifdef VSEQ_PRED_MASK_EN
    issue(3'd0, 3'd1, 3'd2, 3'd3, 6'd16, 32'h0000_F00F, 2, 32'h0000_F00F);
    issue(3'd4, 3'd5, 3'd6, 3'd7, 6'd13, 32'hFFFF_00FF, 2, 32'h0000_00FF);
`endif

    t = 0;
    while ((rd_q.size() + wb_q.size() + done_q.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(rd_q.size() + wb_q.size() + done_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("final_idle", 64'({busy, instr_ready, rf_rd_en, wb_en, done}), 64'b01000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
